// File: rtl/reg_xfer_ctrl_if.sv
// Command, register-read and write-bus signals between the CPU sequencer and
// the register transfer controller.
interface reg_xfer_ctrl_if #(
  parameter int REG_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_src;
  logic [1:0]           cmd_dst;
  logic [REG_WIDTH-1:0] cmd_imm;
  logic [REG_WIDTH-1:0] reg_a_q;
  logic [REG_WIDTH-1:0] reg_x_q;
  logic [REG_WIDTH-1:0] reg_y_q;
  logic [REG_WIDTH-1:0] reg_s_q;
  logic [REG_WIDTH-1:0] bus;
  logic [3:0]           we;
  logic                 flag_we;
  logic                 flag_n;
  logic                 flag_z;
  logic                 done;
  logic                 err;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_imm,
    output reg_a_q, reg_x_q, reg_y_q, reg_s_q,
    input  cmd_ready, bus, we, flag_we, flag_n, flag_z, done, err
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_imm,
    input  reg_a_q, reg_x_q, reg_y_q, reg_s_q,
    output cmd_ready, bus, we, flag_we, flag_n, flag_z, done, err
  );
endinterface

// File: rtl/reg_xfer_ctrl.sv
// Register-to-register / immediate transfer sequencer: IDLE -> FETCH -> WRITE -> DONE.
// Drives the shared write bus, one-hot write enables and N/Z flag updates.
module reg_xfer_ctrl #(
  parameter int REG_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  reg_xfer_ctrl_if.slave xif
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_e;

  state_e               state_q, state_d;
  logic [2:0]           src_q, src_d;
  logic [1:0]           dst_q, dst_d;
  logic [REG_WIDTH-1:0] imm_q, imm_d;
  logic [REG_WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    imm_d         = imm_q;
    data_d        = data_q;
    xif.cmd_ready = 1'b0;
    xif.bus       = '0;
    xif.we        = '0;
    xif.flag_we   = 1'b0;
    xif.flag_n    = 1'b0;
    xif.flag_z    = 1'b0;
    xif.done      = 1'b0;
    xif.err       = 1'b0;
    unique case (state_q)
      IDLE: begin
        xif.cmd_ready = !reset;
        if (xif.cmd_valid) begin
          src_d   = xif.cmd_src;
          dst_d   = xif.cmd_dst;
          imm_d   = xif.cmd_imm;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // Register sources are read here, not at accept, so late updates are seen.
        state_d = WRITE;
        unique case (src_q)
          3'd0:    data_d = xif.reg_a_q;
          3'd1:    data_d = xif.reg_x_q;
          3'd2:    data_d = xif.reg_y_q;
          3'd3:    data_d = xif.reg_s_q;
          3'd4:    data_d = imm_q;
          default: state_d = DONE;
        endcase
      end
      WRITE: begin
        xif.bus = data_q;
        xif.we  = 4'b0001 << dst_q;
        // Writes to S (TXS) leave the status flags alone.
        if (dst_q != 2'd3) begin
          xif.flag_we = 1'b1;
          xif.flag_n  = data_q[REG_WIDTH-1];
          xif.flag_z  = (data_q == '0);
        end
        state_d = DONE;
      end
      DONE: begin
        xif.done = 1'b1;
        xif.err  = (src_q > 3'd4);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl: vector table for single transfers plus
// hand sequences for source timing, back-to-back accept and mid-transfer reset.
module tb_reg_xfer_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [2:0]   src;
    logic [1:0]   dst;
    logic [W-1:0] imm;
    logic [W-1:0] a, x, y, s;
    logic [W-1:0] e_bus;
    logic [3:0]   e_we;
    logic         e_fwe, e_n, e_z, e_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  vec_t vecs[9];

  reg_xfer_ctrl_if #(.REG_WIDTH(W)) bif ();
  reg_xfer_ctrl #(.REG_WIDTH(W)) dut (.clk(clk), .reset(reset), .xif(bif.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bif.cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bif.cmd_ready) chk({nm, "_ready_timeout"}, 32'(bif.cmd_ready), 1);
  endtask

  task automatic run_vec(input vec_t v, input int i);
    string p = $sformatf("v%0d", i);
    bif.reg_a_q = v.a; bif.reg_x_q = v.x; bif.reg_y_q = v.y; bif.reg_s_q = v.s;
    bif.cmd_src = v.src; bif.cmd_dst = v.dst; bif.cmd_imm = v.imm;
    bif.cmd_valid = 1'b1;
    wait_ready(p);
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0;
    @(negedge clk);  // T+1 fetch
    chk({p, "_fetch_we"}, 32'(bif.we), 0);
    chk({p, "_fetch_done"}, 32'(bif.done), 0);
    @(negedge clk);  // T+2
    if (!v.e_err) begin
      chk({p, "_bus"}, 32'(bif.bus), 32'(v.e_bus));
      chk({p, "_we"}, 32'(bif.we), 32'(v.e_we));
      chk({p, "_flag_we"}, 32'(bif.flag_we), 32'(v.e_fwe));
      chk({p, "_flag_n"}, 32'(bif.flag_n), 32'(v.e_n));
      chk({p, "_flag_z"}, 32'(bif.flag_z), 32'(v.e_z));
      chk({p, "_wr_done"}, 32'(bif.done), 0);
    end else begin
      chk({p, "_err_done"}, 32'(bif.done), 1);
      chk({p, "_err_err"}, 32'(bif.err), 1);
      chk({p, "_err_we"}, 32'(bif.we), 0);
      chk({p, "_err_fwe"}, 32'(bif.flag_we), 0);
    end
    @(negedge clk);  // T+3
    if (!v.e_err) begin
      chk({p, "_done"}, 32'(bif.done), 1);
      chk({p, "_err"}, 32'(bif.err), 0);
      chk({p, "_done_we"}, 32'(bif.we), 0);
      @(negedge clk);  // T+4
    end
    chk({p, "_ready_back"}, 32'(bif.cmd_ready), 1);
    chk({p, "_idle_done"}, 32'(bif.done), 0);
  endtask

  initial begin
    int acc[2];
    int k;
    //          src   dst   imm    a      x      y      s      bus    we       fwe   n     z     err
    vecs[0] = '{3'd0, 2'd1, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33, 8'h80, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0}; // TAX
    vecs[1] = '{3'd1, 2'd3, 8'h00, 8'h44, 8'h00, 8'h22, 8'h33, 8'h00, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0}; // TXS
    vecs[2] = '{3'd4, 2'd2, 8'h00, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0}; // LDY #0
    vecs[3] = '{3'd2, 2'd0, 8'h99, 8'h01, 8'h02, 8'h7F, 8'h04, 8'h7F, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0}; // TYA
    vecs[4] = '{3'd3, 2'd1, 8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0}; // TSX
    vecs[5] = '{3'd6, 2'd0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}; // illegal
    vecs[6] = '{3'd0, 2'd0, 8'h00, 8'h00, 8'h02, 8'h03, 8'h04, 8'h00, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0}; // A->A
    vecs[7] = '{3'd7, 2'd3, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}; // illegal
    vecs[8] = '{3'd4, 2'd3, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC3, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0}; // imm->S

    reset = 1'b1;
    bif.cmd_valid = 1'b0; bif.cmd_src = '0; bif.cmd_dst = '0; bif.cmd_imm = '0;
    bif.reg_a_q = '0; bif.reg_x_q = '0; bif.reg_y_q = '0; bif.reg_s_q = '0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", 32'(bif.cmd_ready), 0);
      chk("rst_bus", 32'(bif.bus), 0);
      chk("rst_we", 32'(bif.we), 0);
      chk("rst_flags", {29'd0, bif.flag_we, bif.flag_n, bif.flag_z}, 0);
      chk("rst_done_err", {30'd0, bif.done, bif.err}, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bif.cmd_ready), 1);
    chk("post_rst_we", 32'(bif.we), 0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Source register change after accept is picked up in FETCH.
    bif.reg_a_q = 8'h11; bif.cmd_src = 3'd0; bif.cmd_dst = 2'd2; bif.cmd_valid = 1'b1;
    wait_ready("late_src");
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0; bif.reg_a_q = 8'h22;
    @(negedge clk); @(negedge clk);
    chk("late_src_bus", 32'(bif.bus), 32'h22);
    chk("late_src_we", 32'(bif.we), 32'b0100);
    @(negedge clk); @(negedge clk);

    // Immediate is frozen at accept.
    bif.cmd_src = 3'd4; bif.cmd_dst = 2'd0; bif.cmd_imm = 8'h5A; bif.cmd_valid = 1'b1;
    wait_ready("imm_frz");
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0; bif.cmd_imm = 8'hA5;
    @(negedge clk); @(negedge clk);
    chk("imm_frz_bus", 32'(bif.bus), 32'h5A);
    chk("imm_frz_n", 32'(bif.flag_n), 0);
    @(negedge clk); @(negedge clk);

    // cmd_valid held high: one accept per IDLE visit, 4 cycles apart.
    bif.cmd_src = 3'd4; bif.cmd_dst = 2'd1; bif.cmd_imm = 8'h01; bif.cmd_valid = 1'b1;
    k = 0;
    for (int n = 0; n < 12 && k < 2; n++) begin
      if (bif.cmd_ready && bif.cmd_valid) begin
        acc[k] = cyc;
        k++;
      end
      if (k < 2) @(negedge clk);
    end
    chk("b2b_accepts", 32'(k), 2);
    if (k == 2) chk("b2b_gap", 32'(acc[1] - acc[0]), 4);
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_idle_ready", 32'(bif.cmd_ready), 1);

    // Reset during WRITE drops the command with no completion.
    bif.reg_a_q = 8'h33; bif.cmd_src = 3'd0; bif.cmd_dst = 2'd1; bif.cmd_valid = 1'b1;
    wait_ready("rst_mid");
    @(posedge clk);
    #1 bif.cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_mid_write_we", 32'(bif.we), 32'b0010);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", 32'(bif.we), 0);
    chk("rst_mid_done", 32'(bif.done), 0);
    chk("rst_mid_ready", 32'(bif.cmd_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle_ready", 32'(bif.cmd_ready), 1);
    chk("rst_mid_idle_we", 32'(bif.we), 0);
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("rst_mid_nodone%0d", n), 32'(bif.done), 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/reg_xfer_ctrl.md
Name: reg_xfer_ctrl

Overview:
- Sequences register-to-register transfers (TAX/TXA/TAY/TYA/TSX/TXS style) and immediate loads across the CPU's register instances (A, X, Y, S).
- Accepts one command per valid/ready handshake and captures the source value.
- Drives the shared write bus and one-hot write enables into the register instances.
- Produces N/Z flag updates for the status logic.

Parameters:
- REG_WIDTH, 8, data width of bus, immediate and all register inputs.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_src  input  3  source select: 0=A, 1=X, 2=Y, 3=S, 4=IMM; 5-7 illegal.
- cmd_dst  input  2  destination select: 0=A, 1=X, 2=Y, 3=S.
- cmd_imm  input  REG_WIDTH  immediate value, used when cmd_src=4.
- reg_a_q  input  REG_WIDTH  current A register output.
- reg_x_q  input  REG_WIDTH  current X register output.
- reg_y_q  input  REG_WIDTH  current Y register output.
- reg_s_q  input  REG_WIDTH  current S register output.
- bus  output  REG_WIDTH  shared din to all register instances.
- we  output  4  one-hot write enables; bit0=A, bit1=X, bit2=Y, bit3=S.
- flag_we  output  1  strobe to update N and Z.
- flag_n  output  1  N value (bus MSB).
- flag_z  output  1  Z value (bus == 0).
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle illegal-command pulse, coincident with done.

Behaviour:
- Reset (reset=1 at a rising edge):
  - State goes to IDLE; internal src/dst/imm/data captures clear to 0.
  - bus=0, we=0, flag_we=0, flag_n=0, flag_z=0, done=0, err=0.
  - cmd_ready=0 while reset is high.
- Reset mid-operation: aborts at the next edge with no write issued. A command in flight is dropped and never reported.
- FSM states IDLE, FETCH, WRITE, DONE. All outputs decode from registered state and captured values; there is no combinational path from cmd_* to outputs except cmd_ready.
- IDLE:
  - cmd_ready = 1 (when reset=0).
  - On cmd_valid & cmd_ready at edge T, capture cmd_src, cmd_dst and cmd_imm, then go to FETCH.
  - With cmd_valid=0, stay in IDLE.
- FETCH (cycle T+1):
  - Legal src: data_q <= selected source (reg_*_q or captured imm) at end of cycle, then go to WRITE.
  - Illegal src (5-7): go to DONE with err pending; no write occurs.
- WRITE (cycle T+2):
  - bus = data_q; we[dst] = 1, all other we bits 0. The destination register samples at the end of this cycle.
  - flag_n = data_q[REG_WIDTH-1]; flag_z = (data_q == 0).
  - flag_we = 1 unless dst=S. S-destination transfers (TXS) leave flags untouched; flag_n/flag_z are then 0.
  - Go to DONE.
- DONE (cycle T+3):
  - done = 1; err = 1 only for an illegal src. Go to IDLE.
- Outside WRITE: bus=0, we=0, flag_we=0, flag_n=0, flag_z=0.
- Timing:
  - Latency is accept edge to done high = 3 cycles.
  - Throughput is one command per 4 cycles; the next command is accepted at the earliest at the edge ending the cycle after DONE.
- src == dst is legal: the register rewrites its own value and flags update (except S).
- The source is sampled in FETCH, not at accept. Source changes between accept and FETCH are visible; the immediate is frozen at accept.
- cmd_* are ignored outside IDLE. No buffering: holding cmd_valid high across a transfer yields exactly one acceptance per IDLE visit.

Test Plan:
- Reset then idle: hold reset 2 cycles, release -> all outputs 0 during reset; cmd_ready=1 in the first cycle after release; no we activity.
- TAX: reg_a_q=8'h80, cmd src=0 dst=1 accepted at T -> at T+2 bus=8'h80, we=4'b0010, flag_we=1, flag_n=1, flag_z=0; at T+3 done=1, err=0; cmd_ready=1 at T+4.
- TXS: reg_x_q=8'h00, src=1 dst=3 -> at T+2 we=4'b1000, bus=8'h00, flag_we=0; done at T+3.
- Immediate then back-to-back:
  - src=4, imm=8'h00, dst=2 -> at T+2 we=4'b0100, flag_z=1, flag_n=0.
  - With cmd_valid held high, the second command is accepted exactly 4 cycles after the first.
- Illegal src=6, dst=0 -> we stays 0 and flag_we stays 0 throughout; done=1 and err=1 together at T+2; cmd_ready back at T+3.
- Reset asserted during WRITE of src=0 dst=1 -> we=0 from the next cycle; done never pulses; FSM in IDLE with cmd_ready=1 one cycle after reset drops.
